// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder: operand request in, encoded word out.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32IM encoder: op index + fields -> word, via one stage register into a DEPTH FIFO.
// Word appears two cycles after the handshake into an empty FIFO; illegal requests only pulse err.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  instr_encoder_if.slave bus,
  output logic           err,
  output logic [7:0]     err_count,
  output logic [CW-1:0]  fifo_count
);
  localparam int AW = $clog2(DEPTH);

  logic [5:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        imm12_ok;
  logic        imm13_ok;
  logic        imm21_ok;
  logic [2:0]  f3;
  logic [31:0] enc_word;
  logic        enc_ok;

  logic          stage_valid;
  logic [31:0]   stage_word;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          stage_move;
  logic          accept;

  assign op  = bus.in_op;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign imm = bus.in_imm;

  // Signed range checks reduce to "all bits above the sign bit match it".
  assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign imm13_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign imm21_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];

  always_comb begin
    case (op)
      6'd5, 6'd14, 6'd20, 6'd25, 6'd28:       f3 = 3'd1;
      6'd8, 6'd17, 6'd21, 6'd26:              f3 = 3'd2;
      6'd9, 6'd18:                            f3 = 3'd3;
      6'd2, 6'd11, 6'd22, 6'd29:              f3 = 3'd4;
      6'd6, 6'd7, 6'd15, 6'd16, 6'd23, 6'd30: f3 = 3'd5;
      6'd3, 6'd12, 6'd31:                     f3 = 3'd6;
      6'd4, 6'd13, 6'd32:                     f3 = 3'd7;
      default:                                f3 = (op >= 6'd37) ? 3'(op - 6'd37) : 3'd0;
    endcase
  end

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    if (op <= 6'd9 || (op >= 6'd37 && op <= 6'd44)) begin
      enc_word = {(op >= 6'd37) ? 7'h01 : (op == 6'd1 || op == 6'd7) ? 7'h20 : 7'h00,
                  rs2, rs1, f3, rd, 7'b0110011};
    end else if (op >= 6'd14 && op <= 6'd16) begin
      enc_ok   = (imm[31:5] == '0);
      enc_word = {(op == 6'd16) ? 7'h20 : 7'h00, imm[4:0], rs1, f3, rd, 7'b0010011};
    end else if (op <= 6'd23 || op == 6'd34) begin
      enc_ok   = imm12_ok;
      enc_word = {imm[11:0], rs1, f3, rd,
                  (op <= 6'd18) ? 7'b0010011 : (op == 6'd34) ? 7'b1100111 : 7'b0000011};
    end else if (op <= 6'd26) begin
      enc_ok   = imm12_ok;
      enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    end else if (op <= 6'd32) begin
      enc_ok   = imm13_ok;
      enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    end else if (op == 6'd33) begin
      enc_ok   = imm21_ok;
      enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    end else if (op <= 6'd36) begin
      enc_ok   = (imm[11:0] == '0);
      enc_word = {imm[31:12], rd, (op == 6'd35) ? 7'b0110111 : 7'b0010111};
    end else begin
      enc_ok   = 1'b0;
    end
  end

  assign full          = (fifo_count == CW'(DEPTH));
  assign bus.out_valid = (fifo_count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  assign stage_move    = !full || pop;
  assign push          = stage_valid && stage_move;
  assign bus.in_ready  = !stage_valid || stage_move;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_instr = bus.out_valid ? mem[rd_ptr] : '0;

  // Rejected requests never occupy the stage, so they cannot stall behind a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_word  <= '0;
      err         <= 1'b0;
      err_count   <= '0;
    end else if (flush) begin
      stage_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= accept && !enc_ok;
      if (accept && !enc_ok && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      if (bus.in_ready) begin
        stage_valid <= accept && enc_ok;
        stage_word  <= enc_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= stage_word;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder, scored against an in-bench RV32IM reference encoder.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          err;
  logic [7:0]    err_count;
  logic [CW-1:0] fifo_count;

  instr_encoder_if bus();

  instr_encoder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .err(err), .err_count(err_count), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int f3_tab [45] = '{0,0,4,6,7,1,5,5,2,3, 0,4,6,7,1,5,5,2,3, 0,1,2,4,5, 0,1,2,
                      0,1,4,5,6,7, 0,0, 0,0, 0,1,2,3,4,5,6,7};
  int bnd [12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098,
                   1048574, 1048576, -1048576, 32'h12345000};

  logic [31:0] exp_q [$];
  logic [31:0] seen_q [$];
  int          seen_cyc [$];
  bit          exp_err    = 1'b0;
  int          exp_cnt    = 0;
  int          cyc        = 0;
  int          err_pulses = 0;
  bit          any_valid  = 1'b0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: returns {legal, word}; an illegal request yields all zeros.
  function automatic logic [32:0] ref_enc(input int op, input logic [31:0] rd, input logic [31:0] rs1,
                                          input logic [31:0] rs2, input logic [31:0] iu);
    int          imm;
    bit          ok;
    logic [31:0] w;
    logic [31:0] f3;
    imm = int'(iu);
    if (op < 0 || op > 44) return 33'd0;
    f3 = f3_tab[op];
    ok = 1'b1;
    if (op <= 9 || op >= 37) begin
      w = ((op >= 37) ? 32'd1 : (op == 1 || op == 7) ? 32'd32 : 32'd0) << 25;
      w = w | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
    end else if (op >= 14 && op <= 16) begin
      ok = (iu < 32);
      w = (((op == 16) ? 32'd32 : 32'd0) << 25) | ((iu & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
    end else if (op <= 23 || op == 34) begin
      ok = (imm >= -2048 && imm <= 2047);
      w = ((iu & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) |
          ((op <= 18) ? 32'h13 : (op == 34) ? 32'h67 : 32'h03);
    end else if (op <= 26) begin
      ok = (imm >= -2048 && imm <= 2047);
      w = (((iu >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((iu & 31) << 7) | 32'h23;
    end else if (op <= 32) begin
      ok = (imm >= -4096 && imm <= 4094 && iu[0] == 1'b0);
      w = (((iu >> 12) & 1) << 31) | (((iu >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
          (((iu >> 1) & 15) << 8) | (((iu >> 11) & 1) << 7) | 32'h63;
    end else if (op == 33) begin
      ok = (imm >= -1048576 && imm <= 1048574 && iu[0] == 1'b0);
      w = (((iu >> 20) & 1) << 31) | (((iu >> 1) & 1023) << 21) | (((iu >> 11) & 1) << 20) |
          (((iu >> 12) & 255) << 12) | (rd << 7) | 32'h6F;
    end else begin
      ok = ((iu & 32'hFFF) == 0);
      w = (iu & 32'hFFFFF000) | (rd << 7) | ((op == 35) ? 32'h37 : 32'h17);
    end
    return ok ? {1'b1, w} : 33'd0;
  endfunction

  always @(negedge clk) begin
    logic [32:0] r;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      exp_err = 1'b0;
      exp_cnt = 0;
    end else begin
      check("err", err, exp_err);
      check("err_count", err_count, exp_cnt);
      check("count_vs_valid", bus.out_valid, fifo_count != 0);
      if (err) err_pulses++;
      if (bus.out_valid) begin
        any_valid = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%08h, required no word", bus.out_instr);
        end else begin
          check("out_instr", bus.out_instr, exp_q[0]);
        end
      end else begin
        check("idle_instr_zero", bus.out_instr, 0);
      end
      if (flush) begin
        exp_q.delete();
        exp_err = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          seen_q.push_back(bus.out_instr);
          seen_cyc.push_back(cyc);
        end
        exp_err = 1'b0;
        if (bus.in_valid && bus.in_ready) begin
          r = ref_enc(int'(bus.in_op), 32'(bus.in_rd), 32'(bus.in_rs1), 32'(bus.in_rs2), bus.in_imm);
          if (r[32]) exp_q.push_back(r[31:0]);
          else begin
            exp_err = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
          end
        end
      end
    end
  end

  task automatic drive(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    bus.in_op  = 6'(op);
    bus.in_rd  = 5'(rd);
    bus.in_rs1 = 5'(rs1);
    bus.in_rs2 = 5'(rs2);
    bus.in_imm = imm;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    int n = 0;
    @(posedge clk); #1;
    drive(op, rd, rs1, rs2, imm);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_drain: %0d words pending, required 0", tag, exp_q.size());
    end
  endtask

  task automatic timed_addi(input string tag);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drive(10, 1, 0, 0, 32'd5);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_n1_valid"}, bus.out_valid, 0);
    @(negedge clk);
    check({tag, "_n2_valid"}, bus.out_valid, 1);
    check({tag, "_n2_word"}, bus.out_instr, 32'h00500093);
    @(negedge clk);
    check({tag, "_drained"}, fifo_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int n;
    bit last_hs;
    logic [31:0] w;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 32'd0);
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_fifo_count", fifo_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    check("model_addi", ref_enc(10, 1, 0, 0, 32'd5), {1'b1, 32'h00500093});
    check("model_add", ref_enc(0, 3, 1, 2, 32'd0), {1'b1, 32'h002081B3});
    check("model_mul", ref_enc(37, 5, 6, 7, 32'd0), {1'b1, 32'h027302B3});
    check("model_sw", ref_enc(26, 0, 1, 2, 32'd8), {1'b1, 32'h0020A423});
    check("model_beq", ref_enc(27, 0, 1, 2, -32'sd4), {1'b1, 32'hFE208EE3});
    check("model_srai", ref_enc(16, 1, 2, 0, 32'd3), {1'b1, 32'h40315093});
    check("model_jal", ref_enc(33, 1, 0, 0, 32'h800), {1'b1, 32'h001000EF});
    check("model_lui", ref_enc(35, 5, 0, 0, 32'h12345000), {1'b1, 32'h123452B7});
    check("model_addi_2048", ref_enc(10, 1, 0, 0, 32'd2048), 33'd0);

    timed_addi("addi");

    seen_q.delete();
    seen_cyc.delete();
    send(0, 3, 1, 2, 32'd0);
    send(37, 5, 6, 7, 32'd0);
    send(26, 0, 1, 2, 32'd8);
    send(27, 0, 1, 2, -32'sd4);
    idle();
    wait_drain("b2b");
    check("b2b_count", seen_q.size(), 4);
    if (seen_q.size() == 4) begin
      check("b2b_w0", seen_q[0], 32'h002081B3);
      check("b2b_w1", seen_q[1], 32'h027302B3);
      check("b2b_w2", seen_q[2], 32'h0020A423);
      check("b2b_w3", seen_q[3], 32'hFE208EE3);
      check("b2b_span", seen_cyc[3] - seen_cyc[0], 3);
    end

    any_valid = 1'b0;
    err_pulses = 0;
    send(10, 1, 0, 0, 32'd2048);
    send(50, 1, 0, 0, 32'd0);
    send(27, 0, 1, 2, 32'd3);
    idle();
    repeat (3) @(negedge clk);
    check("rej_pulses", err_pulses, 3);
    check("rej_err_count", err_count, 3);
    check("rej_no_valid", any_valid, 0);

    bus.out_ready = 1'b0;
    seen_q.delete();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      drive(0, acc + 1, 1, 2, 32'd0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
    end
    check("full_accepted", acc, 5);
    check("full_count", fifo_count, 4);
    check("full_in_ready", bus.in_ready, 0);

    @(posedge clk); #1;
    drive(0, 6, 1, 2, 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("pushpop_ready", bus.in_ready, 1);
    idle();
    @(negedge clk);
    check("pushpop_count", fifo_count, 4);
    wait_drain("full");
    check("full_seen", seen_q.size(), 6);
    for (int i = 0; i < 6 && i < seen_q.size(); i++) begin
      w = (32'd2 << 20) | (32'd1 << 15) | (32'(i + 1) << 7) | 32'h33;
      check("full_order", seen_q[i], w);
    end

    bus.out_ready = 1'b0;
    send(0, 7, 1, 2, 32'd0);
    send(0, 8, 1, 2, 32'd0);
    send(0, 9, 1, 2, 32'd0);
    idle();
    n = 0;
    while (fifo_count != 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_fill", fifo_count, 3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_out_instr", bus.out_instr, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_err_count", err_count, 0);
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_err_count", err_count, 0);
    timed_addi("post_rst");

    last_hs = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (!bus.in_valid || last_hs) begin
        case ($urandom_range(0, 5))
          0: w = $urandom_range(0, 31);
          1: w = $urandom;
          2: w = bnd[$urandom_range(0, 11)];
          3: w = $urandom & 32'hFFFFF000;
          4: w = $urandom_range(0, 8191) - 4096;
          default: w = ($urandom_range(0, 2097151) - 1048576) & ~32'd1;
        endcase
        drive($urandom_range(0, 47), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), w);
        bus.in_valid = ($urandom_range(0, 9) < 8);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      last_hs = bus.in_valid && bus.in_ready;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RV32IM instruction encoder. It turns an operation index plus operand fields into a 32-bit instruction word.
- It is the inverse of the core's instruction decoder, and the operation index uses the same bit numbering as the decoder's control-signal vector.
- It feeds self-test, boot and debug instruction-injection paths. Encoded words are buffered in a small FIFO with valid/ready handshakes on both sides.

Parameters:
DEPTH, 4, output FIFO entries (power of two, ≥2)
CW, $clog2(DEPTH)+1, fifo_count width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of stage and FIFO (err_count kept)
in_valid  in  1  request valid
in_ready  out  1  encoder can accept
in_op  in  6  operation index 0..44
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  immediate, byte-offset semantics
out_valid  out  1  out_instr valid
out_ready  in  1  consumer accepts
out_instr  out  32  encoded instruction
err  out  1  one-cycle pulse: request rejected
err_count  out  8  saturating rejected-request count
fifo_count  out  CW  FIFO occupancy

Behaviour:
- Op index map:
  - 0-9: add sub xor or and sll srl sra slt sltu
  - 10-18: addi xori ori andi slli srli srai slti sltiu
  - 19-23: lb lh lw lbu lhu
  - 24-26: sb sh sw
  - 27-32: beq bne blt bge bltu bgeu
  - 33-34: jal jalr
  - 35-36: lui auipc
  - 37-44: mul mulh mulhsu mulhu div divu rem remu
- Encoding is standard RV32IM. Fields not used by a format are forced to 0; for example, rs2 is ignored for I-type.
  - sra: funct7 = 0x20. srai: imm[11:5] = 0x20.
  - M ops: funct7 = 0x01.
  - jalr: funct3 = 0.
- Legality checks; a violation rejects the request:
  - in_op ≤ 44.
  - I/S: in_imm in −2048..2047.
  - Shifts: in_imm[31:5] = 0.
  - B: in_imm in −4096..4094 and in_imm[0] = 0.
  - J: in_imm in −2^20..2^20−2 and in_imm[0] = 0.
  - U: in_imm[11:0] = 0; bits [31:12] form the immediate.
- Pipeline: handshake at N → stage register valid at N+1 → FIFO write at end of N+1 → out_valid at N+2 when the FIFO was empty. Throughput is 1 word/cycle with no backpressure.
- A rejected request is accepted normally:
  - err pulses high in cycle N+1 and err_count increments, saturating at 255.
  - No FIFO write occurs.
- in_ready = !stage_valid || stage moves this cycle. The stage moves when FIFO not full, or when full with out_ready && out_valid.
- FIFO:
  - First-in first-out; out_instr presents the head.
  - out_instr is held stable while out_valid && !out_ready.
  - Simultaneous push and pop when full is legal; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Pop when empty is ignored.
- flush: next cycle stage_valid = 0, FIFO empty, err = 0. A request offered in the flush cycle is dropped. flush has priority over push and pop.
- Reset (rst_n low, any time, including mid-burst) forces all outputs to reset values immediately:
  - in_ready = 1, out_valid = 0, out_instr = 0, err = 0, err_count = 0, fifo_count = 0.
  - Pointers cleared.
- in_ready is low in reset and for the first edge after release? No: in_ready = 1 once rst_n is high.
- out_instr is 0 whenever out_valid = 0.

Test Plan:
- addi rd=1 rs1=0 imm=5, out_ready=1 → out_instr 0x00500093 at N+2; fifo_count returns to 0.
- Back-to-back add x3,x1,x2; mul x5,x6,x7; sw x2,8(x1); beq x1,x2,-4 → 0x002081B3, 0x027302B3, 0x0020A423, 0xFE208EE3 on consecutive cycles.
- addi imm=2048, then in_op=50, then beq imm=3 → err pulses 3 times, err_count=3, out_valid never asserted.
- DEPTH=4, out_ready=0, 6 requests offered → 5 accepted (4 FIFO + stage), fifo_count=4, in_ready=0. Then out_ready=1 → all 5 words emitted in order with no loss or duplication.
- FIFO full, out_ready=1 and in_valid=1 in the same cycle → one pop, one push, fifo_count stays 4.
- rst_n low mid-burst with the FIFO at 3 → out_valid=0 and fifo_count=0 immediately. After release, err_count=0 and the first new request emerges at N+2.
